// File: rtl/aes_result_collector.sv
// aes_result_collector: tracks real launches through a fixed-latency AES pipeline and queues their results behind a valid/ready port.
// Define AES_COLLECT_TAG_EN to carry an 8-bit user tag alongside each block (tag_in/tag_out ports).
module aes_result_collector #(
    parameter int LATENCY = 11,
    parameter int DEPTH   = 4,
    parameter int CW      = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [127:0]  cryptokey,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [127:0]  out_data,
    output logic [CW-1:0] count
`ifdef AES_COLLECT_TAG_EN
    ,
    input  logic [7:0]    tag_in,
    output logic [7:0]    tag_out
`endif
);

    localparam int AW = $clog2(DEPTH);

    logic               launch;
    logic               pop;
    logic               wr;
    logic [LATENCY-1:0] vld_sr_q, vld_sr_d;
    logic [CW-1:0]      credits_q, credits_d;
    logic [CW-1:0]      count_q, count_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [127:0]       mem_q [DEPTH];

    // Credits cover in-flight plus stored results, so a granted launch always has a FIFO slot waiting.
    assign in_ready  = (credits_q < CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign launch    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign wr        = vld_sr_q[LATENCY-1];
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign count     = count_q;

    // NOTE: every _d gets its hold value first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        vld_sr_d  = vld_sr_q;
        credits_d = credits_q;
        count_d   = count_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;

        vld_sr_d[0] = launch;
        for (int i = 1; i < LATENCY; i++) begin
            vld_sr_d[i] = vld_sr_q[i-1];
        end

        if (launch && !pop) begin
            credits_d = credits_q + CW'(1);
        end else if (pop && !launch) begin
            credits_d = credits_q - CW'(1);
        end

        if (wr && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !wr) begin
            count_d = count_q - CW'(1);
        end

        if (wr) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_sr_q  <= '0;
            credits_q <= '0;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            vld_sr_q  <= vld_sr_d;
            credits_q <= credits_d;
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
        end
    end

    // NOTE: storage carries no reset; out_valid gates what leaves it, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem_q[wr_ptr_q] <= cryptokey;
        end
    end

`ifdef AES_COLLECT_TAG_EN
    logic [7:0] tag_sr_q  [LATENCY];
    logic [7:0] tag_sr_d  [LATENCY];
    logic [7:0] tag_mem_q [DEPTH];

    always_comb begin
        tag_sr_d[0] = launch ? tag_in : '0;
        for (int i = 1; i < LATENCY; i++) begin
            tag_sr_d[i] = tag_sr_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        tag_sr_q <= tag_sr_d;
        if (wr) begin
            tag_mem_q[wr_ptr_q] <= tag_sr_q[LATENCY-1];
        end
    end

    assign tag_out = out_valid ? tag_mem_q[rd_ptr_q] : '0;
`endif

endmodule

// File: tb/tb_aes_result_collector.sv
// Bench for aes_result_collector: an AES stand-in delay line feeds known ciphertexts; a launch-ordered scoreboard checks every cycle.
// Tag checks are compiled in when AES_COLLECT_TAG_EN is defined.
`timescale 1ns/1ps
module tb_aes_result_collector;

    localparam int LATENCY = 11;
    localparam int DEPTH   = 4;
    localparam int CW      = 3;

    localparam logic [127:0] PT_A  = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] KEY_A = 128'h0f1571c947d9e8590cb7add6af7f6798;
    localparam logic [127:0] CT_A  = 128'hff0b844a0853bf7c6934ab4364148fb9;
    localparam logic [127:0] PT_B  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_B  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [127:0]  cryptokey;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [127:0]  out_data;
    logic [CW-1:0] count;
    logic [127:0]  data_in = '0;
    logic [127:0]  key_in = '0;
`ifdef AES_COLLECT_TAG_EN
    logic [7:0]    tag_in = '0;
    logic [7:0]    tag_out;
`endif
    logic [7:0]    next_tag = 8'h01;

    aes_result_collector #(.LATENCY(LATENCY), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cryptokey (cryptokey),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
`ifdef AES_COLLECT_TAG_EN
        ,
        .tag_in    (tag_in),
        .tag_out   (tag_out)
`endif
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // AES stand-in: knows only the two reference vectors; anything else yields a recognisable junk value.
    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
        if (pt == PT_A && k == KEY_A) return CT_A;
        if (pt == PT_B && k == KEY_B) return CT_B;
        return pt ^ {k[63:0], k[127:64]};
    endfunction

    logic [127:0] aes_pipe [LATENCY];
    always @(posedge clk) begin
        aes_pipe[0] <= aes_ref(data_in, key_in);
        for (int i = 1; i < LATENCY; i++) aes_pipe[i] <= aes_pipe[i-1];
    end
    assign cryptokey = aes_pipe[LATENCY-1];

    typedef struct {
        logic [127:0] ct;
        logic [7:0]   tag;
        int           launch_edge;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    function automatic logic [127:0] junk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One cycle: at the negedge compare DUT state against the scoreboard, update the model, then drive inputs.
    task automatic drive_cycle(input logic v, input logic [127:0] pt, input logic [127:0] k,
                               input logic rdy, output logic dut_launch, output logic dut_pop);
        int           landed;
        logic         exp_valid;
        logic         exp_ready;
        logic [127:0] exp_data;
        logic [7:0]   exp_tag;
        exp_t         e;
        @(negedge clk);
        landed = 0;
        foreach (sb[i]) if (edge_cnt >= sb[i].launch_edge + LATENCY) landed++;
        exp_valid = (landed != 0);
        exp_ready = (sb.size() < DEPTH);
        exp_data  = exp_valid ? sb[0].ct : '0;
        exp_tag   = exp_valid ? sb[0].tag : '0;

        n_total++;
        if (in_ready !== exp_ready) $display("FAIL in_ready edge=%0d got=%b exp=%b", edge_cnt, in_ready, exp_ready);
        else n_pass++;
        n_total++;
        if (out_valid !== exp_valid) $display("FAIL out_valid edge=%0d got=%b exp=%b", edge_cnt, out_valid, exp_valid);
        else n_pass++;
        n_total++;
        if (count !== CW'(landed)) $display("FAIL count edge=%0d got=%0d exp=%0d", edge_cnt, count, landed);
        else n_pass++;
        n_total++;
        if (out_data !== exp_data) $display("FAIL out_data edge=%0d got=%h exp=%h", edge_cnt, out_data, exp_data);
        else n_pass++;
`ifdef AES_COLLECT_TAG_EN
        n_total++;
        if (tag_out !== exp_tag) $display("FAIL tag_out edge=%0d got=%h exp=%h", edge_cnt, tag_out, exp_tag);
        else n_pass++;
`endif

        dut_launch = v && in_ready;
        dut_pop    = out_valid && rdy;
        if (exp_valid && rdy) e = sb.pop_front();
        if (v && exp_ready) begin
            e.ct          = aes_ref(pt, k);
            e.tag         = next_tag;
            e.launch_edge = edge_cnt + 1;
            sb.push_back(e);
        end

        in_valid  = v;
        out_ready = rdy;
        data_in   = pt;
        key_in    = k;
`ifdef AES_COLLECT_TAG_EN
        tag_in    = next_tag;
`endif
        if (v && exp_ready) next_tag = next_tag + 8'd1;
    endtask

    task automatic drain(input int n);
        logic l, p;
        repeat (n) drive_cycle(1'b0, junk(), junk(), 1'b1, l, p);
    endtask

    task automatic check_reset_outputs(input string name);
        n_total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || count !== '0 || out_data !== '0)
            $display("FAIL %s got in_ready=%b out_valid=%b count=%0d out_data=%h exp 1/0/0/0",
                     name, in_ready, out_valid, count, out_data);
        else n_pass++;
`ifdef AES_COLLECT_TAG_EN
        n_total++;
        if (tag_out !== 8'h00) $display("FAIL %s_tag got=%h exp=00", name, tag_out);
        else n_pass++;
`endif
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        check_reset_outputs("reset_init");
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_single();
        logic l, p;
        int   e0;
        drive_cycle(1'b1, PT_A, KEY_A, 1'b0, l, p);
        e0 = edge_cnt + 1;
        for (int k = 0; k < LATENCY + 3; k++) begin
            drive_cycle(1'b0, junk(), junk(), 1'b0, l, p);
            if (edge_cnt == e0 + LATENCY - 1) begin
                n_total++;
                if (out_valid !== 1'b0) $display("FAIL single_early got=%b exp=0", out_valid);
                else n_pass++;
            end
            if (edge_cnt == e0 + LATENCY) begin
                n_total++;
                if (out_valid !== 1'b1 || out_data !== CT_A)
                    $display("FAIL single_land got=%b/%h exp=1/%h", out_valid, out_data, CT_A);
                else n_pass++;
            end
        end
        n_total++;
        if (out_data !== CT_A) $display("FAIL single_hold got=%h exp=%h", out_data, CT_A);
        else n_pass++;
        drain(3);
    endtask

    task automatic test_back_to_back();
        logic l, p;
        int   n_launch = 0;
        int   n_pop = 0;
        int   run = 0;
        int   best_run = 0;
        for (int c = 0; c < 200 && n_launch < 12; c++) begin
            drive_cycle(1'b1, n_launch[0] ? PT_B : PT_A, n_launch[0] ? KEY_B : KEY_A, 1'b1, l, p);
            if (l) n_launch++;
            if (p) n_pop++;
            run = out_valid ? run + 1 : 0;
            if (run > best_run) best_run = run;
        end
        for (int c = 0; c < LATENCY + 4; c++) begin
            drive_cycle(1'b0, junk(), junk(), 1'b1, l, p);
            if (p) n_pop++;
            run = out_valid ? run + 1 : 0;
            if (run > best_run) best_run = run;
        end
        n_total++;
        if (n_launch != 12 || n_pop != 12) $display("FAIL b2b_totals got launch=%0d pop=%0d exp=12/12", n_launch, n_pop);
        else n_pass++;
        n_total++;
        if (best_run < DEPTH) $display("FAIL b2b_burst got run=%0d exp>=%0d", best_run, DEPTH);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic l, p;
        int   n_launch = 0;
        repeat (LATENCY + 10) begin
            drive_cycle(1'b1, PT_B, KEY_B, 1'b0, l, p);
            if (l) n_launch++;
        end
        n_total++;
        if (n_launch != DEPTH) $display("FAIL bp_launches got=%0d exp=%0d", n_launch, DEPTH);
        else n_pass++;
        n_total++;
        if (count !== CW'(DEPTH) || in_ready !== 1'b0)
            $display("FAIL bp_full got count=%0d in_ready=%b exp %0d/0", count, in_ready, DEPTH);
        else n_pass++;
        drive_cycle(1'b1, PT_A, KEY_A, 1'b1, l, p);
        drive_cycle(1'b0, junk(), junk(), 1'b1, l, p);
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL bp_release got in_ready=%b exp=1", in_ready);
        else n_pass++;
        drain(LATENCY + 6);
    endtask

    task automatic test_idle_gaps();
        logic l, p;
        int   launches = 0;
        int   pops = 0;
        for (int b = 0; b < 6; b++) begin
            drive_cycle(1'b1, b[0] ? PT_A : PT_B, b[0] ? KEY_A : KEY_B, 1'($urandom_range(0, 1)), l, p);
            if (l) launches++;
            if (p) pops++;
            repeat (3) begin
                drive_cycle(1'b0, junk(), junk(), 1'($urandom_range(0, 1)), l, p);
                if (p) pops++;
                n_total++;
                if (int'(count) > launches - pops)
                    $display("FAIL gap_count got=%0d exp<=%0d", count, launches - pops);
                else n_pass++;
            end
        end
        drain(LATENCY + 8);
    endtask

    task automatic test_reset_midstream();
        logic l, p;
        repeat (3) drive_cycle(1'b1, PT_A, KEY_A, 1'b0, l, p);
        repeat (LATENCY - 1) drive_cycle(1'b0, junk(), junk(), 1'b0, l, p);
        drive_cycle(1'b1, PT_B, KEY_B, 1'b1, l, p);
        #2 reset = 1'b0;
        #1 check_reset_outputs("reset_mid");
        sb.delete();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        drain(LATENCY + 4);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_idle_gaps();
        test_reset_midstream();
        n_total++;
        if (sb.size() != 0) $display("FAIL sb_leftover got=%0d exp=0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
